id_ex_stage_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection and a WB->ID write-through bypass.
//  It sits between decode and execute and supplies ID_EXRegisterRs/Rt and the EX control bits that the

---
 rtl/id_ex_stage_reg_pkg.sv | 19 +
 rtl/id_ex_stage_reg_hazard.sv | 26 ++
 rtl/id_ex_stage_reg.sv | 132 +++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared pipeline widths, ALU op codes, register-zero and bubble-control constants
package id_ex_stage_reg_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int REG_ZERO    = 0;
  localparam int CTRL_W      = 6;
  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;
  // {RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}; all-zero so a bubble has no side effects
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_stage_reg_hazard.sv
// load_use_hazard_detect: combinational load-use detection driving stall, PCWrite and IF_IDWrite
module load_use_hazard_detect
  import id_ex_stage_reg_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               id_ex_valid_i,
  input  logic               id_ex_mem_read_i,
  input  logic [RADDR_W-1:0] id_ex_rt_i,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic               id_uses_rt_i,
  input  logic               ex_flush_i,
  output logic               stall_o,
  output logic               pc_write_o,
  output logic               if_id_write_o
);
  logic load_use;
  assign load_use = id_ex_valid_i & id_ex_mem_read_i & (id_ex_rt_i != RADDR_W'(REG_ZERO)) & id_valid_i &
                    ((id_ex_rt_i == id_rs_i) | (id_uses_rt_i & (id_ex_rt_i == id_rt_i)));
  // A redirect kills the dependent instruction anyway, so it never stalls
  assign stall_o       = load_use & ~ex_flush_i;
  assign pc_write_o    = ~stall_o;
  assign if_id_write_o = ~stall_o;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall, flush bubbles, WB write-through and stall counter
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ID_Valid,
  input  logic [DATA_W-1:0]  ID_PC4,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_SignExtImm,
  input  logic [RADDR_W-1:0] ID_RegisterRs,
  input  logic [RADDR_W-1:0] ID_RegisterRt,
  input  logic [RADDR_W-1:0] ID_RegisterRd,
  input  logic               ID_UsesRt,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               MEM_WBRegWrite,
  input  logic [RADDR_W-1:0] MEM_WBRegisterRd,
  input  logic [DATA_W-1:0]  MEM_WBWriteData,
  input  logic               EX_Flush,
  output logic               ID_EXValid,
  output logic [DATA_W-1:0]  ID_EXPC4,
  output logic [DATA_W-1:0]  ID_EXReadData1,
  output logic [DATA_W-1:0]  ID_EXReadData2,
  output logic [DATA_W-1:0]  ID_EXSignExtImm,
  output logic [RADDR_W-1:0] ID_EXRegisterRs,
  output logic [RADDR_W-1:0] ID_EXRegisterRt,
  output logic [RADDR_W-1:0] ID_EXRegisterRd,
  output logic               ID_EXRegDst,
  output logic               ID_EXALUSrc,
  output logic               ID_EXMemRead,
  output logic               ID_EXMemWrite,
  output logic               ID_EXRegWrite,
  output logic               ID_EXMemtoReg,
  output logic [ALUOP_W-1:0] ID_EXALUOp,
  output logic               PCWrite,
  output logic               IF_IDWrite,
  output logic [CNT_W-1:0]   StallCount
);
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stall, bubble, wb_hit, byp1, byp2;

  load_use_hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
    .id_ex_valid_i    (valid_q),
    .id_ex_mem_read_i (ctrl_q[3]),
    .id_ex_rt_i       (rt_q),
    .id_valid_i       (ID_Valid),
    .id_rs_i          (ID_RegisterRs),
    .id_rt_i          (ID_RegisterRt),
    .id_uses_rt_i     (ID_UsesRt),
    .ex_flush_i       (EX_Flush),
    .stall_o          (stall),
    .pc_write_o       (PCWrite),
    .if_id_write_o    (IF_IDWrite)
  );

  assign bubble = EX_Flush | stall | ~ID_Valid;
  assign wb_hit = MEM_WBRegWrite & (MEM_WBRegisterRd != RADDR_W'(REG_ZERO));
  assign byp1   = wb_hit & (MEM_WBRegisterRd == ID_RegisterRs);
  assign byp2   = wb_hit & (MEM_WBRegisterRd == ID_RegisterRt);

  // Data fields latch unconditionally; a bubble is made harmless by its cleared valid, controls and addresses
  always_comb begin
    valid_d = ~bubble;
    pc4_d   = ID_PC4;
    rd1_d   = byp1 ? MEM_WBWriteData : ID_ReadData1;
    rd2_d   = byp2 ? MEM_WBWriteData : ID_ReadData2;
    imm_d   = ID_SignExtImm;
    rs_d    = bubble ? RADDR_W'(REG_ZERO) : ID_RegisterRs;
    rt_d    = bubble ? RADDR_W'(REG_ZERO) : ID_RegisterRt;
    rd_d    = bubble ? RADDR_W'(REG_ZERO) : ID_RegisterRd;
    ctrl_d  = bubble ? BUBBLE_CTRL : {ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg};
    aluop_d = bubble ? '0 : ID_ALUOp;
    cnt_d   = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      aluop_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ID_EXValid      = valid_q;
  assign ID_EXPC4        = pc4_q;
  assign ID_EXReadData1  = rd1_q;
  assign ID_EXReadData2  = rd2_q;
  assign ID_EXSignExtImm = imm_q;
  assign ID_EXRegisterRs = rs_q;
  assign ID_EXRegisterRt = rt_q;
  assign ID_EXRegisterRd = rd_q;
  assign {ID_EXRegDst, ID_EXALUSrc, ID_EXMemRead, ID_EXMemWrite, ID_EXRegWrite, ID_EXMemtoReg} = ctrl_q;
  assign ID_EXALUOp      = aluop_q;
  assign StallCount      = cnt_q;
endmodule
